// File: rtl/md_nb_pkg.sv
// Shared slot geometry for the neighbor beat sequencer: shell sizes, the
// 27-entry neighbor offset table and the periodic-wrap index helper.
package md_nb_pkg;

  localparam int HALF_SHELL_SLOTS = 14;
  localparam int FULL_SHELL_SLOTS = 27;
  localparam int SLOT_W           = 5;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
    logic signed [1:0] dz;
  } nb_offset_t;

  localparam logic signed [1:0] P1 = 2'sb01;
  localparam logic signed [1:0] Z0 = 2'sb00;
  localparam logic signed [1:0] M1 = 2'sb11;

  // Slots 14..26 are the negations of slots 1..13, in that order.
  localparam nb_offset_t NB_OFFSET [FULL_SHELL_SLOTS] = '{
    '{Z0, Z0, Z0}, '{P1, Z0, Z0}, '{M1, P1, Z0}, '{Z0, P1, Z0},
    '{P1, P1, Z0}, '{M1, M1, P1}, '{Z0, M1, P1}, '{P1, M1, P1},
    '{M1, Z0, P1}, '{Z0, Z0, P1}, '{P1, Z0, P1}, '{M1, P1, P1},
    '{Z0, P1, P1}, '{P1, P1, P1},
    '{M1, Z0, Z0}, '{P1, M1, Z0}, '{Z0, M1, Z0}, '{M1, M1, Z0},
    '{P1, P1, M1}, '{Z0, P1, M1}, '{M1, P1, M1}, '{P1, Z0, M1},
    '{Z0, Z0, M1}, '{M1, Z0, M1}, '{P1, M1, M1}, '{Z0, M1, M1},
    '{M1, M1, M1}
  };

  function automatic int axis_wrap(input int pos, input logic [1:0] d, input int dim);
    int step;
    step = (d == 2'b01) ? 1 : ((d == 2'b11) ? -1 : 0);
    return (pos + step + dim) % dim;
  endfunction

  function automatic int nb_cell_index(input int home_idx, input nb_offset_t offset,
                                       input int x_dim, input int y_dim, input int z_dim);
    int x, y, z;
    x = home_idx % x_dim;
    y = (home_idx / x_dim) % y_dim;
    z = home_idx / (x_dim * y_dim);
    return axis_wrap(z, offset.dz, z_dim) * x_dim * y_dim
         + axis_wrap(y, offset.dy, y_dim) * x_dim
         + axis_wrap(x, offset.dx, x_dim);
  endfunction

endpackage

// File: rtl/nb_position_beat_sequencer_lane_mux.sv
// Combinational lane selector: for every home cell and lane, routes the
// snapshot word of the neighbor at slot base+lane, or zero when that slot is unused.
module nb_lane_mux
  import md_nb_pkg::*;
#(
  parameter int X_DIM           = 4,
  parameter int Y_DIM           = 4,
  parameter int Z_DIM           = 4,
  parameter int POS_CACHE_WIDTH = 87,
  parameter int NUM_LANES       = 7
) (
  input  logic [X_DIM*Y_DIM*Z_DIM*POS_CACHE_WIDTH-1:0]           snapshot,
  input  logic                                                   full_shell,
  input  logic                                                   active,
  input  logic [SLOT_W-1:0]                                      slot_base,
  output logic [X_DIM*Y_DIM*Z_DIM*NUM_LANES*POS_CACHE_WIDTH-1:0] position,
  output logic [NUM_LANES-1:0]                                   lane_valid
);

  localparam int NUM_CELLS = X_DIM * Y_DIM * Z_DIM;
  localparam int PW        = POS_CACHE_WIDTH;

  logic [SLOT_W:0] slot_count;
  logic [SLOT_W:0] lane_slot [NUM_LANES];

  assign slot_count = full_shell ? (SLOT_W+1)'(FULL_SHELL_SLOTS) : (SLOT_W+1)'(HALF_SHELL_SLOTS);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_slot[l]  = {1'b0, slot_base} + (SLOT_W+1)'(l);
    assign lane_valid[l] = active && (lane_slot[l] < slot_count);
  end

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    // Neighbor wiring is fixed at elaboration; only the slot select is dynamic.
    logic [PW-1:0] nb_word [2**SLOT_W];
    for (genvar s = 0; s < 2**SLOT_W; s++) begin : g_slot
      if (s < FULL_SHELL_SLOTS) begin : g_real
        localparam int NBR = nb_cell_index(c, NB_OFFSET[s], X_DIM, Y_DIM, Z_DIM);
        assign nb_word[s] = snapshot[NBR*PW +: PW];
      end else begin : g_pad
        assign nb_word[s] = '0;
      end
    end
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_out
      assign position[(c*NUM_LANES+l)*PW +: PW] =
        lane_valid[l] ? nb_word[lane_slot[l][SLOT_W-1:0]] : '0;
    end
  end

endmodule

// File: rtl/nb_position_beat_sequencer.sv
// Snapshots one position-cache readout row per handshake and streams every
// home cell's neighbor positions to the PE array, NUM_LANES slots per beat.
module nb_position_beat_sequencer
  import md_nb_pkg::*;
#(
  parameter int X_DIM           = 4,
  parameter int Y_DIM           = 4,
  parameter int Z_DIM           = 4,
  parameter int NUM_CELLS       = X_DIM * Y_DIM * Z_DIM,
  parameter int OFFSET_WIDTH    = 29,
  parameter int POS_CACHE_WIDTH = 3 * OFFSET_WIDTH,
  parameter int NUM_LANES       = 7
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         shell_mode,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [NUM_CELLS*POS_CACHE_WIDTH-1:0]           rd_nb_position,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [NUM_CELLS*NUM_LANES*POS_CACHE_WIDTH-1:0] out_position,
  output logic [NUM_LANES-1:0]                         out_lane_valid,
  output logic [SLOT_W-1:0]                            out_slot_base,
  output logic                                         out_last,
  output logic                                         busy
);

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  localparam logic [SLOT_W-1:0] LAST_BEAT_HALF =
    SLOT_W'((HALF_SHELL_SLOTS + NUM_LANES - 1) / NUM_LANES - 1);
  localparam logic [SLOT_W-1:0] LAST_BEAT_FULL =
    SLOT_W'((FULL_SHELL_SLOTS + NUM_LANES - 1) / NUM_LANES - 1);

  state_t                               state, state_next;
  logic [SLOT_W-1:0]                    beat, beat_next, last_beat;
  logic [NUM_CELLS*POS_CACHE_WIDTH-1:0] snapshot;
  logic                                 full_shell, capture, emit;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a valid side holds its payload until then.
  // A snapshot may be taken in the same cycle the previous last beat leaves.
  assign emit      = (state == EMIT);
  assign busy      = emit;
  assign out_valid = emit;
  assign last_beat = full_shell ? LAST_BEAT_FULL : LAST_BEAT_HALF;
  assign out_last  = emit && (beat == last_beat);
  assign in_ready  = !rst && (!emit || (out_ready && out_last));
  assign capture   = in_valid && in_ready;

  assign out_slot_base = SLOT_W'(int'(beat) * NUM_LANES);

  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (capture) begin
          state_next = EMIT;
          beat_next  = '0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!out_last) begin
            beat_next = beat + SLOT_W'(1);
          end else begin
            beat_next  = '0;
            state_next = capture ? EMIT : IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      snapshot   <= '0;
      full_shell <= 1'b0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      if (capture) begin
        snapshot   <= rd_nb_position;
        full_shell <= shell_mode;
      end
    end
  end

  nb_lane_mux #(
    .X_DIM           (X_DIM),
    .Y_DIM           (Y_DIM),
    .Z_DIM           (Z_DIM),
    .POS_CACHE_WIDTH (POS_CACHE_WIDTH),
    .NUM_LANES       (NUM_LANES)
  ) u_lane_mux (
    .snapshot   (snapshot),
    .full_shell (full_shell),
    .active     (emit),
    .slot_base  (out_slot_base),
    .position   (out_position),
    .lane_valid (out_lane_valid)
  );

endmodule

// File: tb/tb_nb_position_beat_sequencer.sv
// Scoreboard bench: a 4x4x4 and a 5x3x2 instance, directed snapshots with
// hand-computed neighbor values plus an independent per-axis wrap model.
module tb_nb_position_beat_sequencer;

  localparam int PW    = 87;
  localparam int L     = 7;
  localparam int NA    = 64;
  localparam int NB    = 30;
  localparam int MAXW  = NA * L * PW;
  localparam int EXP_W = 18;  // {tag[3:0], mode, base[4:0], lane_valid[6:0], last}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic              a_mode = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic              a_out_last, a_busy;
  logic [NA*PW-1:0]  a_rd = '0;
  logic [NA*L*PW-1:0] a_out_position;
  logic [L-1:0]      a_out_lane_valid;
  logic [4:0]        a_out_slot_base;

  logic              b_mode = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic              b_out_last, b_busy;
  logic [NB*PW-1:0]  b_rd = '0;
  logic [NB*L*PW-1:0] b_out_position;
  logic [L-1:0]      b_out_lane_valid;
  logic [4:0]        b_out_slot_base;

  logic [EXP_W-1:0] exp_q_a[$];
  logic [EXP_W-1:0] exp_q_b[$];
  logic [EXP_W-1:0] mon_e;

  int half_ofs [14][3] = '{'{0,0,0}, '{1,0,0}, '{-1,1,0}, '{0,1,0}, '{1,1,0},
                           '{-1,-1,1}, '{0,-1,1}, '{1,-1,1}, '{-1,0,1}, '{0,0,1},
                           '{1,0,1}, '{-1,1,1}, '{0,1,1}, '{1,1,1}};

  // Hand-computed neighbor values for rd[c] = c (tag 0).
  localparam int N_SPOT = 10;
  int spot_dut  [N_SPOT] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int spot_cell [N_SPOT] = '{0, 0, 0, 63, 0, 0, 0, 0, 0, 29};
  int spot_slot [N_SPOT] = '{1, 2, 5, 13, 7, 14, 26, 8, 2, 13};
  int spot_val  [N_SPOT] = '{1, 7, 31, 0, 29, 3, 63, 19, 9, 0};

  nb_position_beat_sequencer #(.X_DIM(4), .Y_DIM(4), .Z_DIM(4), .NUM_LANES(L)) dut_a (
    .clk(clk), .rst(rst), .shell_mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rd_nb_position(a_rd), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_position(a_out_position), .out_lane_valid(a_out_lane_valid),
    .out_slot_base(a_out_slot_base), .out_last(a_out_last), .busy(a_busy));

  nb_position_beat_sequencer #(.X_DIM(5), .Y_DIM(3), .Z_DIM(2), .NUM_LANES(L)) dut_b (
    .clk(clk), .rst(rst), .shell_mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rd_nb_position(b_rd), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_position(b_out_position), .out_lane_valid(b_out_lane_valid),
    .out_slot_base(b_out_slot_base), .out_last(b_out_last), .busy(b_busy));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, required test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, want);
    end
  endtask

  function automatic logic [PW-1:0] pat_word(input int tag, input int idx);
    if (tag == 0) return PW'(idx);
    return {29'(tag), 29'(idx * 5 + 1), 29'(idx + tag * 64)};
  endfunction

  function automatic int nbr_ref(input int c, input int s, input int xd, input int yd, input int zd);
    int m, sg, x, y, z;
    m  = (s > 13) ? s - 13 : s;
    sg = (s > 13) ? -1 : 1;
    x = (c % xd + sg * half_ofs[m][0] + xd) % xd;
    y = ((c / xd) % yd + sg * half_ofs[m][1] + yd) % yd;
    z = (c / (xd * yd) + sg * half_ofs[m][2] + zd) % zd;
    return (z * yd + y) * xd + x;
  endfunction

  task automatic fill_rd(input int d, input int tag);
    if (d == 0) for (int c = 0; c < NA; c++) a_rd[c*PW +: PW] = pat_word(tag, c);
    else        for (int c = 0; c < NB; c++) b_rd[c*PW +: PW] = pat_word(tag, c);
  endtask

  // ---------------- driver ----------------
  task automatic send(input int d, input int tag, input bit mode, input bit hold, output int acc_cyc);
    bit acc;
    int n, s_cnt, nbeats, base;
    logic [L-1:0] lv;
    acc = 0;
    n = 0;
    fill_rd(d, tag);
    if (d == 0) begin a_mode = mode; a_in_valid = 1; end
    else        begin b_mode = mode; b_in_valid = 1; end
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (d == 0) ? a_in_ready : b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    check(d == 0 ? "a_send_accept" : "b_send_accept", acc, 1);
    if (acc) begin
      s_cnt  = mode ? 27 : 14;
      nbeats = (s_cnt + L - 1) / L;
      for (int b = 0; b < nbeats; b++) begin
        base = b * L;
        lv = '0;
        for (int l = 0; l < L; l++) if (base + l < s_cnt) lv[l] = 1'b1;
        if (d == 0) exp_q_a.push_back({4'(tag), mode, 5'(base), lv, (b == nbeats - 1)});
        else        exp_q_b.push_back({4'(tag), mode, 5'(base), lv, (b == nbeats - 1)});
      end
    end
    // Flipping shell_mode after capture must not disturb the stream in flight.
    if (d == 0) begin a_in_valid = hold; a_mode = ~mode; end
    else        begin b_in_valid = hold; b_mode = ~mode; end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (n < 100 && ((d == 0) ? exp_q_a.size() : exp_q_b.size()) != 0) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(d == 0 ? "a_drain_left" : "b_drain_left", (d == 0) ? exp_q_a.size() : exp_q_b.size(), 0);
    @(negedge clk);
    check(d == 0 ? "a_idle_busy" : "b_idle_busy", (d == 0) ? a_busy : b_busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input int d);
    if (d == 0) begin
      check("a_q_valid", a_out_valid, 0);
      check("a_q_busy", a_busy, 0);
      check("a_q_in_ready", a_in_ready, 1);
      check("a_q_last", a_out_last, 0);
      check("a_q_base", a_out_slot_base, 0);
      check("a_q_lane_valid", a_out_lane_valid, 0);
      check("a_q_pos_nonzero", |a_out_position, 0);
    end else begin
      check("b_q_valid", b_out_valid, 0);
      check("b_q_busy", b_busy, 0);
      check("b_q_in_ready", b_in_ready, 1);
      check("b_q_last", b_out_last, 0);
      check("b_q_base", b_out_slot_base, 0);
      check("b_q_lane_valid", b_out_lane_valid, 0);
      check("b_q_pos_nonzero", |b_out_position, 0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_beat(input int d, input logic [EXP_W-1:0] e, input logic [MAXW-1:0] pos,
                            input logic [4:0] base, input logic [L-1:0] lv, input logic last);
    int tag, s_cnt, ebase, ncell, xd, yd, zd, slot;
    logic [PW-1:0] w, xw, gw, ew;
    bit bad;
    string pfx;
    tag   = int'(e[17:14]);
    s_cnt = e[13] ? 27 : 14;
    ebase = int'(e[12:8]);
    pfx   = (d == 0) ? "a" : "b";
    if (d == 0) begin ncell = NA; xd = 4; yd = 4; zd = 4; end
    else        begin ncell = NB; xd = 5; yd = 3; zd = 2; end
    check({pfx, "_slot_base"}, base, e[12:8]);
    check({pfx, "_lane_valid"}, lv, e[7:1]);
    check({pfx, "_last"}, last, e[0]);
    bad = 0;
    gw = '0;
    ew = '0;
    for (int c = 0; c < ncell; c++) begin
      for (int l = 0; l < L; l++) begin
        slot = ebase + l;
        w  = pos[(c*L+l)*PW +: PW];
        xw = (slot < s_cnt) ? pat_word(tag, nbr_ref(c, slot, xd, yd, zd)) : '0;
        if (c == 0 && l == 0) begin gw = w; ew = xw; end
        if (w !== xw && !bad) begin
          bad = 1;
          gw = w;
          ew = xw;
          $display("  beat data detail %s cell=%0d lane=%0d slot=%0d", pfx, c, l, slot);
        end
      end
    end
    check({pfx, "_beat_data"}, gw, ew);
    for (int i = 0; i < N_SPOT; i++) begin
      if (spot_dut[i] == d && tag == 0 && spot_slot[i] >= ebase && spot_slot[i] < ebase + L
          && spot_slot[i] < s_cnt)
        check($sformatf("%s_spot_c%0d_s%0d", pfx, spot_cell[i], spot_slot[i]),
              pos[(spot_cell[i]*L + spot_slot[i] - ebase)*PW +: PW], spot_val[i]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_q_a.size() == 0) check("a_beat_without_expectation", 0, 1);
      else begin
        mon_e = exp_q_a.pop_front();
        check_beat(0, mon_e, MAXW'(a_out_position), a_out_slot_base, a_out_lane_valid, a_out_last);
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_q_b.size() == 0) check("b_beat_without_expectation", 0, 1);
      else begin
        mon_e = exp_q_b.pop_front();
        check_beat(1, mon_e, MAXW'(b_out_position), b_out_slot_base, b_out_lane_valid, b_out_last);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t1, t2;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("a_in_ready_in_reset", a_in_ready, 0);
    check("b_in_ready_in_reset", b_in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_quiet(0);
    check_quiet(1);
    @(posedge clk);
    #1;

    // 4x4x4 half shell then full shell, rd[c] = c
    send(0, 0, 0, 0, t1);
    wait_drain(0);
    send(0, 0, 1, 0, t1);
    wait_drain(0);

    // 5x3x2 full shell and half shell
    send(1, 0, 1, 0, t1);
    wait_drain(1);
    send(1, 2, 0, 0, t1);
    wait_drain(1);

    // Stall on beat 1 of a full-shell stream while the readout row changes
    send(0, 0, 1, 0, t1);
    @(posedge clk);
    #1;
    a_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      fill_rd(0, 7 + (i % 2));
      @(negedge clk);
      check("a_stall_valid", a_out_valid, 1);
      check("a_stall_base", a_out_slot_base, 7);
      check("a_stall_lane_valid", a_out_lane_valid, 7'h7F);
      check("a_stall_last", a_out_last, 0);
      check("a_stall_c0_slot7", a_out_position[PW-1:0], 29);
      @(posedge clk);
      #1;
    end
    a_out_ready = 1;
    wait_drain(0);

    // Back-to-back half-shell snapshots: no bubble between them
    send(0, 1, 0, 1, t1);
    send(0, 2, 0, 0, t2);
    check("a_b2b_accept_gap", t2 - t1, 2);
    wait_drain(0);

    // Reset while beat 1 of a full-shell stream is presented
    send(0, 2, 1, 0, t1);
    @(posedge clk);
    #1;
    rst = 1;
    exp_q_a.delete();
    @(negedge clk);
    check("a_in_ready_during_rst", a_in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check_quiet(0);
    @(posedge clk);
    #1;
    send(0, 1, 1, 0, t1);
    wait_drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
